bambu_mem_host_initiator: RTL and testbench
===========================================

Name: bambu_mem_host_initiator

Overview:
Synthesizable host-side initiator for the Bambu minimal-memory interface of an HLS-generated `main` core. It writes an input byte stream into the core's memory space starting at a base address, pulses `start_port`, and counts cycles until `done_port`. It then reads back a result region byte by byte and streams it out. It sits between a host byte-stream link and the core's `S_*` slave memory port, driving the `Mout_*` master side of that protocol.

Parameters:
ADDR_W, 7, per-channel byte address width (channel k address occupies `Mout_addr_ram[k*ADDR_W +: ADDR_W]`)
TIMEOUT_CYCLES, 200000000, maximum run cycles before abort

Ports:
clock  in  1  single clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
cmd_go  in  1  one-cycle command strobe, honoured only in IDLE
cfg_base_addr  in  7  first byte address of the load/read region
cfg_load_len  in  8  bytes to write before start (0..128)
cfg_read_len  in  8  bytes to read back after done (0..128)
in_data  in  8  load byte
in_valid  in  1  load byte valid
in_ready  out  1  load byte accepted when in_valid&in_ready
out_data  out  8  readback byte
out_valid  out  1  readback byte valid
out_ready  in  1  consumer accepts readback byte
start_port  out  1  one-cycle start pulse to core
done_port  in  1  core completion
Mout_oe_ram  out  2  read enable per channel
Mout_we_ram  out  2  write enable per channel
Mout_addr_ram  out  14  two 7-bit addresses
Mout_Wdata_ram  out  16  two 8-bit write bytes
Mout_data_ram_size  out  8  two 4-bit access sizes in bits
M_Rdata_ram  in  16  two 8-bit read bytes
M_DataRdy  in  2  per-channel access complete
busy  out  1  high in every state except IDLE
error  out  1  sticky error flag
cycles  out  32  measured run length

Behaviour:
- Reset values: all outputs 0; state IDLE; `cycles` 0; `error` 0.
- Channel 1 is always idle: `oe[1]`, `we[1]`, `addr[13:7]`, `Wdata[15:8]`, and `size[7:4]` are all 0.
- Channel 0 drives `size[3:0]` = 8 while `oe[0]` or `we[0]` is high, and 0 otherwise.
- Addresses are `base + index` using 8-bit unsigned arithmetic.
- Range check on `cmd_go`: if `base + load_len > 128` or `base + read_len > 128`, go to ERR. Otherwise clear `error` and `cycles`, reset the index, and go to LOAD.
- `cmd_go` outside IDLE is ignored.
- LOAD:
  - Skipped when `load_len` = 0.
  - `in_ready` = 1; on handshake, capture the byte and go to WR.
- WR:
  - Drive `we[0]`=1, `addr`, `Wdata`, holding all three stable until a cycle with `M_DataRdy[0]`=1.
  - The next cycle `we[0]`=0 and the index increments.
  - If the index reaches `load_len`, go to START; otherwise return to LOAD.
  - `oe` and `we` are never high together.
- START:
  - `start_port`=1 for exactly one cycle, then RUN.
  - `cycles` is loaded with 1 in the START cycle.
- RUN:
  - `cycles` increments each cycle while `done_port`=0.
  - On `done_port`=1, `cycles` is frozen, including the done cycle; reset the index and go to RD, or DONE if `read_len` = 0.
  - If `cycles` reaches `TIMEOUT_CYCLES` without done, go to ERR.
  - `done_port` sampled in START counts and ends the run with `cycles`=1.
- RD:
  - Drive `oe[0]`=1 with a stable `addr` until `M_DataRdy[0]`=1.
  - Capture `M_Rdata_ram[7:0]` in that same cycle, drop `oe[0]` the next cycle, and go to OUT.
- OUT:
  - `out_valid`=1, with `out_data` held until `out_ready`.
  - On handshake, increment the index; go to RD, or to DONE when the index reaches `read_len`.
- DONE: return to IDLE after one cycle; `cycles` holds its value until the next accepted `cmd_go`.
- ERR:
  - Set `error`=1 and deassert all bus enables.
  - Return to IDLE the next cycle; `error` remains sticky until the next accepted `cmd_go` or reset.
- Reset mid-operation: abandons the transfer immediately; enables drop in the reset cycle, with no partial write completion required.
- `M_DataRdy` seen while no access is pending is ignored.
- Minimum write latency is 1 cycle after enable; read latency is arbitrary, including the 2-cycle responder case.

Test Plan:
- base=0, load_len=3 bytes {0x11,0x22,0x33}, responder write latency 1 -> three `we[0]` pulses at addr 0,1,2 with Wdata 0x11/0x22/0x33 and size=8, then a single `start_port` pulse.
- done_port asserted 10 cycles after the start pulse -> `cycles`=11, `busy` drops after DONE, `error`=0.
- read_len=4, base=5, 2-cycle read responder returning addr^0x5A -> `out_data` sequence 0x5F,0x5C,0x5D,0x52, each held while `out_ready`=0 for 3 cycles.
- base=120, load_len=9 -> ERR, `error`=1, no bus activity, no `start_port`; the next valid `cmd_go` clears `error`.
- TIMEOUT_CYCLES=16 with done never asserted -> `error`=1 after 16 run cycles, and `cycles` holds 16.
- reset asserted while `we[0]` is held awaiting DataRdy -> next cycle all outputs 0 and state IDLE; a subsequent cmd_go runs normally.

Source files
------------

// File: rtl/bambu_mem_host_initiator.sv
// Host-side initiator for the Bambu minimal-memory interface of an HLS `main` core.
// It writes a host byte stream into core memory from a base address, pulses start_port,
// times the run until done_port, then reads a result region back out as a byte stream.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   cmd_go, cfg_*           command strobe (honoured in IDLE only) and its region/lengths
//   in_data/valid/ready     load byte stream (valid/ready handshake)
//   out_data/valid/ready    readback byte stream (valid/ready handshake)
//   start_port, done_port   core start pulse and completion input
//   Mout_*, M_Rdata_ram,
//   M_DataRdy               two-channel master memory port; only channel 0 is used
//   busy, error, cycles     status: not idle, sticky error, measured run length
module bambu_mem_host_initiator #(
    parameter int unsigned ADDR_W         = 7,
    parameter int unsigned TIMEOUT_CYCLES = 200000000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_go,
    input  logic [ADDR_W-1:0]     cfg_base_addr,
    input  logic [7:0]            cfg_load_len,
    input  logic [7:0]            cfg_read_len,
    input  logic [7:0]            in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  start_port,
    input  logic                  done_port,
    output logic [1:0]            Mout_oe_ram,
    output logic [1:0]            Mout_we_ram,
    output logic [2*ADDR_W-1:0]   Mout_addr_ram,
    output logic [15:0]           Mout_Wdata_ram,
    output logic [7:0]            Mout_data_ram_size,
    input  logic [15:0]           M_Rdata_ram,
    input  logic [1:0]            M_DataRdy,
    output logic                  busy,
    output logic                  error,
    output logic [31:0]           cycles
);

    localparam int unsigned MEM_BYTES = 1 << ADDR_W;
    localparam logic [3:0]  ACC_BITS  = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE, S_LOAD, S_WR, S_START, S_RUN, S_RD, S_OUT, S_DONE, S_ERR
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [7:0]        load_len_q;
    logic [7:0]        read_len_q;
    logic [7:0]        idx;
    logic              oe0;
    logic              we0;
    logic [ADDR_W-1:0] addr0;
    logic [7:0]        wdata0;
    logic [3:0]        size0;

    logic       load_oob;
    logic       read_oob;
    logic [7:0] idx_next;
    logic       unused_inputs;

    // Region must fit entirely inside the addressable byte space.
    assign load_oob = (32'(cfg_base_addr) + 32'(cfg_load_len)) > MEM_BYTES;
    assign read_oob = (32'(cfg_base_addr) + 32'(cfg_read_len)) > MEM_BYTES;
    assign idx_next = idx + 8'd1;

    // Channel 1 is never used; its fields are tied to zero.
    assign Mout_oe_ram        = {1'b0, oe0};
    assign Mout_we_ram        = {1'b0, we0};
    assign Mout_addr_ram      = {{ADDR_W{1'b0}}, addr0};
    assign Mout_Wdata_ram     = {8'd0, wdata0};
    assign Mout_data_ram_size = {4'd0, size0};
    assign unused_inputs      = ^{M_Rdata_ram[15:8], M_DataRdy[1]};

    // Control FSM with all outputs registered alongside the state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            base_q     <= '0;
            load_len_q <= '0;
            read_len_q <= '0;
            idx        <= '0;
            oe0        <= 1'b0;
            we0        <= 1'b0;
            addr0      <= '0;
            wdata0     <= '0;
            size0      <= '0;
            in_ready   <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            start_port <= 1'b0;
            busy       <= 1'b0;
            error      <= 1'b0;
            cycles     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_go) begin
                        busy       <= 1'b1;
                        base_q     <= cfg_base_addr;
                        load_len_q <= cfg_load_len;
                        read_len_q <= cfg_read_len;
                        idx        <= '0;
                        if (load_oob || read_oob) begin
                            error <= 1'b1;
                            state <= S_ERR;
                        end else begin
                            error <= 1'b0;
                            if (cfg_load_len == 8'd0) begin
                                start_port <= 1'b1;
                                cycles     <= 32'd1;
                                state      <= S_START;
                            end else begin
                                cycles   <= '0;
                                in_ready <= 1'b1;
                                state    <= S_LOAD;
                            end
                        end
                    end
                end

                S_LOAD: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        wdata0   <= in_data;
                        we0      <= 1'b1;
                        size0    <= ACC_BITS;
                        addr0    <= base_q + ADDR_W'(idx);
                        state    <= S_WR;
                    end
                end

                // Write held stable until the slave acknowledges it.
                S_WR: begin
                    if (M_DataRdy[0]) begin
                        we0   <= 1'b0;
                        size0 <= '0;
                        idx   <= idx_next;
                        if (idx_next == load_len_q) begin
                            start_port <= 1'b1;
                            cycles     <= 32'd1;
                            state      <= S_START;
                        end else begin
                            in_ready <= 1'b1;
                            state    <= S_LOAD;
                        end
                    end
                end

                // cycles counts START through the done cycle inclusive.
                S_START, S_RUN: begin
                    start_port <= 1'b0;
                    if (done_port) begin
                        idx <= '0;
                        if (read_len_q == 8'd0) begin
                            state <= S_DONE;
                        end else begin
                            oe0   <= 1'b1;
                            size0 <= ACC_BITS;
                            addr0 <= base_q;
                            state <= S_RD;
                        end
                    end else if (cycles >= TIMEOUT_CYCLES) begin
                        error <= 1'b1;
                        state <= S_ERR;
                    end else begin
                        cycles <= cycles + 32'd1;
                        state  <= S_RUN;
                    end
                end

                S_RD: begin
                    if (M_DataRdy[0]) begin
                        oe0       <= 1'b0;
                        size0     <= '0;
                        out_data  <= M_Rdata_ram[7:0];
                        out_valid <= 1'b1;
                        state     <= S_OUT;
                    end
                end

                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        idx       <= idx_next;
                        if (idx_next == read_len_q) begin
                            state <= S_DONE;
                        end else begin
                            oe0   <= 1'b1;
                            size0 <= ACC_BITS;
                            addr0 <= base_q + ADDR_W'(idx_next);
                            state <= S_RD;
                        end
                    end
                end

                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                S_ERR: begin
                    oe0   <= 1'b0;
                    we0   <= 1'b0;
                    size0 <= '0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bambu_mem_host_initiator.sv
// Self-checking bench for bambu_mem_host_initiator: a memory responder with
// configurable latency plus a transaction-level reference model of each command.
`timescale 1ns/1ps
module tb_bambu_mem_host_initiator;

    localparam int unsigned ADDR_W    = 7;
    localparam int          TMO       = 16;
    localparam int          MEM_BYTES = 128;
    localparam int          BUDGET    = 400;

    logic                clock = 1'b0;
    logic                reset = 1'b1;
    logic                cmd_go = 1'b0;
    logic [ADDR_W-1:0]   cfg_base_addr = '0;
    logic [7:0]          cfg_load_len = '0;
    logic [7:0]          cfg_read_len = '0;
    logic [7:0]          in_data = '0;
    logic                in_valid = 1'b0;
    logic                in_ready;
    logic [7:0]          out_data;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic                start_port;
    logic                done_port = 1'b0;
    logic [1:0]          Mout_oe_ram;
    logic [1:0]          Mout_we_ram;
    logic [2*ADDR_W-1:0] Mout_addr_ram;
    logic [15:0]         Mout_Wdata_ram;
    logic [7:0]          Mout_data_ram_size;
    logic [15:0]         M_Rdata_ram = '0;
    logic [1:0]          M_DataRdy = '0;
    logic                busy;
    logic                error;
    logic [31:0]         cycles;

    bambu_mem_host_initiator #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .cmd_go(cmd_go),
        .cfg_base_addr(cfg_base_addr), .cfg_load_len(cfg_load_len), .cfg_read_len(cfg_read_len),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .start_port(start_port), .done_port(done_port),
        .Mout_oe_ram(Mout_oe_ram), .Mout_we_ram(Mout_we_ram), .Mout_addr_ram(Mout_addr_ram),
        .Mout_Wdata_ram(Mout_Wdata_ram), .Mout_data_ram_size(Mout_data_ram_size),
        .M_Rdata_ram(M_Rdata_ram), .M_DataRdy(M_DataRdy),
        .busy(busy), .error(error), .cycles(cycles)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Responder memory (what the core holds) and the model's expected memory.
    logic [7:0]        resp_mem [MEM_BYTES];
    logic [7:0]        exp_mem  [MEM_BYTES];
    logic [ADDR_W+7:0] wr_log [$];
    logic [7:0]        load_bytes [$];
    int                wr_lat = 1;
    int                rd_lat = 2;
    bit                spur_en = 1'b0;
    int                acc_cnt = 0;
    logic [ADDR_W-1:0] acc_addr = '0;
    logic [7:0]        acc_wdata = '0;
    int                n_start = 0;
    int                n_en = 0;
    int                model_cycles = 0;

    // Slave responder: acknowledges an access `latency` cycles after its enable rises.
    always @(negedge clock) begin
        if (reset) begin
            M_DataRdy = 2'b00;
            acc_cnt   = 0;
        end else begin
            if (start_port) n_start++;
            M_DataRdy = 2'b00;
            if (Mout_we_ram[0] || Mout_oe_ram[0]) begin
                n_en++;
                if (acc_cnt == 0) begin
                    acc_addr  = Mout_addr_ram[ADDR_W-1:0];
                    acc_wdata = Mout_Wdata_ram[7:0];
                end
                if (acc_cnt == (Mout_we_ram[0] ? wr_lat : rd_lat)) begin
                    M_DataRdy = 2'b01;
                    check("oe_we_excl", Mout_we_ram[0] & Mout_oe_ram[0], 0);
                    check("acc_size", Mout_data_ram_size, 8'h08);
                    check("ch1_idle", {Mout_oe_ram[1], Mout_we_ram[1], Mout_addr_ram[2*ADDR_W-1:ADDR_W],
                                       Mout_Wdata_ram[15:8]}, 0);
                    check("addr_stable", Mout_addr_ram[ADDR_W-1:0], acc_addr);
                    if (Mout_we_ram[0]) begin
                        check("wdata_stable", Mout_Wdata_ram[7:0], acc_wdata);
                        resp_mem[Mout_addr_ram[ADDR_W-1:0]] = Mout_Wdata_ram[7:0];
                        wr_log.push_back({Mout_addr_ram[ADDR_W-1:0], Mout_Wdata_ram[7:0]});
                    end else begin
                        M_Rdata_ram = {8'($urandom), resp_mem[Mout_addr_ram[ADDR_W-1:0]]};
                    end
                end
                acc_cnt++;
            end else begin
                acc_cnt = 0;
                if (spur_en && $urandom_range(0, 3) == 0) begin
                    M_DataRdy   = 2'($urandom_range(1, 3));
                    M_Rdata_ram = 16'($urandom);
                end
            end
        end
    end

    // One command end to end; dly<0 means done_port is never raised, stall<0 means random.
    task automatic run_cmd(input int base, input int ld, input int rd, input int dly, input int stall);
        logic [7:0] bytes [$];
        bit  oob, run_ok;
        int  cnt, s0, e0, nrd, k;
        logic [7:0] exp_b;
        oob    = (base + ld > MEM_BYTES) || (base + rd > MEM_BYTES);
        run_ok = !oob && dly >= 0 && (dly + 1) <= TMO;
        for (int i = 0; i < ld; i++)
            bytes.push_back(i < load_bytes.size() ? load_bytes[i] : 8'($urandom));
        if (!oob) begin
            for (int i = 0; i < ld; i++) exp_mem[ADDR_W'(base + i)] = bytes[i];
            model_cycles = run_ok ? dly + 1 : TMO;
        end
        nrd = run_ok ? rd : 0;
        wr_log.delete();
        s0 = n_start;
        e0 = n_en;

        cfg_base_addr = ADDR_W'(base);
        cfg_load_len  = 8'(ld);
        cfg_read_len  = 8'(rd);
        cmd_go = 1'b1;
        @(negedge clock);
        cmd_go = 1'b0;
        check("accept_busy", busy, 1);
        check("accept_err", error, oob);

        if (!oob) begin
            foreach (bytes[i]) begin
                repeat ($urandom_range(0, 2)) @(negedge clock);
                in_data  = bytes[i];
                in_valid = 1'b1;
                cnt = 0;
                while (!in_ready && cnt < BUDGET) begin @(negedge clock); cnt++; end
                check("load_wait", cnt < BUDGET, 1);
                @(negedge clock);
                in_valid = 1'b0;
            end
            cnt = 0;
            while (!start_port && cnt < BUDGET) begin @(negedge clock); cnt++; end
            check("start_wait", cnt < BUDGET, 1);
            if (run_ok && dly == 0) begin
                done_port = 1'b1;
                @(negedge clock);
                done_port = 1'b0;
                check("start_one_cycle", start_port, 0);
            end else begin
                @(negedge clock);
                check("start_one_cycle", start_port, 0);
                if (run_ok) begin
                    // A command strobe while busy must be ignored.
                    cfg_base_addr = ADDR_W'($urandom);
                    cfg_load_len  = 8'($urandom);
                    cfg_read_len  = 8'($urandom);
                    cmd_go = 1'b1;
                    repeat (dly - 1) @(negedge clock);
                    cmd_go = 1'b0;
                    done_port = 1'b1;
                    @(negedge clock);
                    done_port = 1'b0;
                end
            end
            for (int i = 0; i < nrd; i++) begin
                exp_b = exp_mem[ADDR_W'(base + i)];
                cnt = 0;
                while (!out_valid && cnt < BUDGET) begin @(negedge clock); cnt++; end
                check("out_wait", cnt < BUDGET, 1);
                check("rd_data", out_data, exp_b);
                k = stall < 0 ? int'($urandom_range(0, 3)) : stall;
                repeat (k) @(negedge clock);
                check("rd_hold", {out_valid, out_data}, {1'b1, exp_b});
                out_ready = 1'b1;
                @(negedge clock);
                out_ready = 1'b0;
            end
        end

        cnt = 0;
        while (busy && cnt < BUDGET) begin @(negedge clock); cnt++; end
        check("idle_wait", cnt < BUDGET, 1);
        check("end_error", error, !run_ok);
        check("end_cycles", cycles, model_cycles);
        check("end_out_valid", out_valid, 0);
        check("start_pulses", n_start - s0, oob ? 0 : 1);
        check("wr_count", wr_log.size(), oob ? 0 : ld);
        if (oob) check("err_no_bus", n_en - e0, 0);
        for (int i = 0; i < ld && i < wr_log.size(); i++)
            check("wr_entry", wr_log[i], {ADDR_W'(base + i), bytes[i]});
        load_bytes.delete();
    endtask

    initial begin
        int cnt;
        for (int a = 0; a < MEM_BYTES; a++) begin
            resp_mem[a] = 8'(a) ^ 8'h5A;
            exp_mem[a]  = 8'(a) ^ 8'h5A;
        end

        repeat (3) @(negedge clock);
        check("rst_outputs", {in_ready, out_data, out_valid, start_port, Mout_oe_ram, Mout_we_ram,
                              Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size, busy, error, cycles}, '0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_outputs", {in_ready, out_valid, start_port, Mout_oe_ram, Mout_we_ram, busy, error, cycles}, '0);

        // Three-byte load with 1-cycle writes, done 10 cycles after start.
        wr_lat = 1;
        load_bytes = '{8'h11, 8'h22, 8'h33};
        run_cmd(0, 3, 0, 10, 0);

        // Readback from base 5 with a 2-cycle responder and a 3-cycle consumer stall.
        rd_lat = 2;
        run_cmd(5, 0, 4, 2, 3);

        // Out-of-range regions, then a valid command clears the error.
        run_cmd(120, 9, 0, 3, 0);
        run_cmd(100, 0, 29, 3, 0);
        run_cmd(120, 8, 8, 4, 1);

        // Run-length boundaries: done in START, done on the last allowed cycle, timeout.
        run_cmd(30, 2, 2, 0, 0);
        run_cmd(40, 1, 1, TMO - 1, 0);
        run_cmd(50, 2, 3, -1, 0);

        // Reset while a write is held awaiting its acknowledge.
        wr_lat = 40;
        wr_log.delete();
        cfg_base_addr = 7'd10;
        cfg_load_len  = 8'd2;
        cfg_read_len  = 8'd1;
        cmd_go = 1'b1;
        @(negedge clock);
        cmd_go   = 1'b0;
        in_data  = 8'hA5;
        in_valid = 1'b1;
        cnt = 0;
        while (!Mout_we_ram[0] && cnt < BUDGET) begin @(negedge clock); cnt++; end
        check("we_wait", cnt < BUDGET, 1);
        in_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("midrst_outputs", {in_ready, out_data, out_valid, start_port, Mout_oe_ram, Mout_we_ram,
                                 Mout_addr_ram, Mout_Wdata_ram, Mout_data_ram_size, busy, error, cycles}, '0);
        reset = 1'b0;
        model_cycles = 0;
        wr_lat = 1;
        @(negedge clock);
        check("midrst_nowrite", wr_log.size(), 0);
        run_cmd(10, 2, 2, 5, -1);

        // Randomized commands with spurious acknowledges and varying latencies.
        spur_en = 1'b1;
        for (int t = 0; t < 20; t++) begin
            wr_lat = $urandom_range(1, 3);
            rd_lat = $urandom_range(1, 3);
            run_cmd($urandom_range(0, 127), $urandom_range(0, 10), $urandom_range(0, 10),
                    ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 12)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
